ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test initiator for the 32Kx4 dual-port RAM.
- Drives the RAM's write-enable, address and data-in on both ports and consumes its data-out.
- Runs a March C- algorithm over the whole array and reports pass/fail with first-fault diagnostics.
- Sits beside the RAM. It owns the RAM ports while busy; port muxing with the functional path is external.

Parameters:
ADDR_W, 15, RAM address width (depth = 2**ADDR_W)
DATA_W, 4, RAM word width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  level-sampled run request
busy  output  1  test in progress
done  output  1  test finished; held until next start or rst
pass  output  1  valid when done; 1 = no mismatch
fail_addr  output  ADDR_W  address of first mismatch
fail_elem  output  3  march element (0-5) of first mismatch
fail_data  output  DATA_W  data read at first mismatch
fail_port  output  1  port of first mismatch (0 = port 1, 1 = port 2)
ram_rw_1  output  1  port-1 write enable (1 = write)
ram_addr_1  output  ADDR_W  port-1 address
ram_din_1  output  DATA_W  port-1 write data
ram_dout_1  input  DATA_W  port-1 read data
ram_rw_2  output  1  port-2 write enable, always 0
ram_addr_2  output  ADDR_W  port-2 address, always bitwise complement of ram_addr_1
ram_din_2  output  DATA_W  port-2 write data, always 0
ram_dout_2  input  DATA_W  port-2 read data

Behaviour:
- RAM timing contract: address is registered at a clk edge; dout is valid combinationally during the following cycle. A read issued in cycle t is therefore compared in cycle t+1.
- Reset values: busy=0, done=0, pass=0, all fail_* = 0, ram_rw_1=0, ram_addr_1=0, ram_din_1=0. State = IDLE.
- States: IDLE -> RUN -> FLUSH -> DONE.
  - IDLE: start=1 -> RUN; busy=1 from the next cycle; all results cleared.
  - DONE: start=1 restarts the test, identical to IDLE.
  - RUN/FLUSH: start is ignored.
- March elements, in order (D0 = all zeros, D1 = all ones):
  - M0 up (w D0)
  - M1 up (r D0, w D1)
  - M2 up (r D1, w D0)
  - M3 down (r D0, w D1)
  - M4 down (r D1, w D0)
  - M5 up (r D0)
- Element execution:
  - Up = address 0 to max; down = max to 0.
  - Each r,w pair takes two cycles at the same address: read cycle (rw_1=0), then write cycle (rw_1=1).
  - Single-op elements take one cycle per address.
  - No idle cycles between elements.
- Compare pipeline:
  - A registered valid, expected value, address and element follow each read by one cycle.
  - Mismatch -> latch diagnostics (first fault only) and abort: deassert rw_1, go to DONE with pass=0.
  - The read issued in the previous cycle is discarded.
- FLUSH: one cycle after the last M5 read, to compare it. Then DONE with pass=1 if no mismatch.
- Run length:
  - Fault-free busy duration = 10*2**ADDR_W + 1 cycles.
  - done=1, busy=0 in the cycle after FLUSH.
- Port 2:
  - ram_addr_2 = ~ram_addr_1, so the two ports never address the same word.
  - This avoids the RAM's same-address X output on port 2.
- Reset mid-run: the next cycle is in IDLE with reset values. No write is issued after the rst edge.
- Address counter: no wrap. The element advances on the terminal address (max for up, 0 for down).

Optional Feature:
RAM_BIST_PORT2_CHECK_EN
- Defined: during M5, ram_dout_2 is also compared against D0 one cycle after each read. A port-2 mismatch reports fail_port=1, with fail_addr = the complement address. Port 1 has priority if both ports mismatch in the same cycle.
- Undefined: ram_dout_2 is ignored and fail_port is tied 0. Port-2 outputs are unchanged.

Decomposition:
- Package ram_bist_pkg holds:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - element index constants M0..M5
  - per-element direction and expected/written background tables
  - D0/D1 constants
- Sub-module march_addr_gen: loadable up/down ADDR_W counter with a terminal-count flag, instantiated once.

Test Plan:
1. ADDR_W=4, fault-free RAM model; start pulse -> busy for exactly 161 cycles, then done=1, pass=1, fail_addr=0.
2. ADDR_W=4, bit0 stuck-at-1 at address 5 -> done, pass=0, fail_addr=5, fail_elem=1, fail_data=0001, fail_port=0.
3. ADDR_W=4, coupling fault where a write to addr 3 also writes addr 4 -> pass=0, fail_addr=4, fail_elem=1, fail_data=1111.
4. rst asserted in run cycle 50 -> next cycle busy=0, ram_rw_1=0; a subsequent start gives a full fault-free run, pass=1.
5. start held high through the run, then pulsed in DONE -> no effect during the run; the restart clears fail_*/pass and re-runs 161 cycles.
6. RAM_BIST_PORT2_CHECK_EN defined, model corrupts ram_dout_2 to 0100 when port 2 reads addr 10 -> pass=0, fail_port=1, fail_addr=10, fail_elem=5, fail_data=0100.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: FSM states, March C- element tables and data backgrounds for ram_march_bist.
package ram_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    localparam logic D0 = 1'b0;
    localparam logic D1 = 1'b1;

    // Bit i of each table describes element Mi; backgrounds expand D0/D1 to the word width.
    localparam logic [5:0] ELEM_DOWN  = 6'b011000;
    localparam logic [5:0] ELEM_RD    = 6'b111110;
    localparam logic [5:0] ELEM_WR    = 6'b011111;
    localparam logic [5:0] ELEM_RD_BG = {D0, D1, D0, D1, D0, D0};
    localparam logic [5:0] ELEM_WR_BG = {D0, D0, D1, D0, D1, D0};

endpackage

// File: rtl/march_addr_gen.sv
// march_addr_gen: loadable up/down address counter with a terminal-count flag.
module march_addr_gen #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic              down,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst)
            addr <= '0;
        else if (load)
            addr <= load_val;
        else if (en)
            addr <= down ? addr - ONE : addr + ONE;
    end

    assign tc = down ? (addr == '0) : (&addr);

endmodule

// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- self-test initiator for a dual-port RAM with first-fault capture.
// RAM_BIST_PORT2_CHECK_EN additionally checks port-2 read data during the final read-only element.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data,
    output logic              fail_port,
    output logic              ram_rw_1,
    output logic [ADDR_W-1:0] ram_addr_1,
    output logic [DATA_W-1:0] ram_din_1,
    input  logic [DATA_W-1:0] ram_dout_1,
    output logic              ram_rw_2,
    output logic [ADDR_W-1:0] ram_addr_2,
    output logic [DATA_W-1:0] ram_din_2,
    input  logic [DATA_W-1:0] ram_dout_2
);
    state_t            state, next_state;
    logic [2:0]        elem, elem_nx, cmp_elem;
    logic [ADDR_W-1:0] addr, load_val, cmp_addr;
    logic              ph, tc, go, pair, op_rd, op_wr, step, elem_end;
    logic              mm1, mm2, mm, cmp_valid, cmp_bg, cmp_m5;

    assign go       = (state == IDLE || state == DONE) && start;
    assign pair     = ELEM_RD[elem] && ELEM_WR[elem];
    assign op_rd    = ELEM_RD[elem] && !(pair && ph);
    assign op_wr    = ELEM_WR[elem] && !(pair && !ph);
    assign step     = state == RUN && !mm && (!pair || ph);
    assign elem_end = step && tc;
    assign elem_nx  = elem + 3'd1;
    assign load_val = (go || !ELEM_DOWN[elem_nx]) ? '0 : '1;

    assign mm1 = cmp_valid && ram_dout_1 != {DATA_W{cmp_bg}};
`ifdef RAM_BIST_PORT2_CHECK_EN
    assign mm2 = cmp_valid && cmp_m5 && ram_dout_2 != {DATA_W{D0}};
`else
    logic unused_m5;
    assign unused_m5 = cmp_m5;
    assign mm2 = 1'b0;
`endif
    assign mm = mm1 || mm2;

    march_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (go || elem_end),
        .en       (step && !tc),
        .down     (ELEM_DOWN[elem]),
        .load_val (load_val),
        .addr     (addr),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = start ? RUN : state;
            RUN:        next_state = mm ? DONE : (elem_end && elem == M5) ? FLUSH : RUN;
            FLUSH:      next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // A mismatch suppresses the write presented in the same cycle.
    always_comb begin
        busy      = state == RUN || state == FLUSH;
        done      = state == DONE;
        ram_rw_1  = state == RUN && op_wr && !mm;
        ram_din_1 = ram_rw_1 ? {DATA_W{ELEM_WR_BG[elem]}} : '0;
    end

    assign ram_addr_1 = addr;
    assign ram_rw_2   = 1'b0;
    assign ram_addr_2 = ~addr;
    assign ram_din_2  = '0;

    always_ff @(posedge clk) begin
        if (rst || go) begin
            elem      <= M0;
            ph        <= 1'b0;
            cmp_valid <= 1'b0;
            cmp_bg    <= D0;
            cmp_m5    <= 1'b0;
            cmp_addr  <= '0;
            cmp_elem  <= M0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
            fail_port <= 1'b0;
        end else begin
            cmp_valid <= state == RUN && op_rd && !mm;
            cmp_bg    <= ELEM_RD_BG[elem];
            cmp_m5    <= elem == M5;
            cmp_addr  <= addr;
            cmp_elem  <= elem;
            if (state == RUN && !mm)
                ph <= pair && !ph;
            if (elem_end && elem != M5)
                elem <= elem_nx;
            if (state == FLUSH && !mm)
                pass <= 1'b1;
            if (mm) begin
                fail_addr <= mm1 ? cmp_addr : ~cmp_addr;
                fail_elem <= cmp_elem;
                fail_data <= mm1 ? ram_dout_1 : ram_dout_2;
                fail_port <= !mm1;
            end
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: scoreboarded bench driving ram_march_bist against a faultable 16x4 RAM model.
`timescale 1ns/1ps
module tb_ram_march_bist;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int N  = 1 << AW;

    typedef enum int {F_NONE, F_STUCK, F_COUPLE, F_P2} fault_e;
    typedef struct {
        bit pass;
        int addr;
        int elem;
        int data;
        int port;
        int cycles;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, fail_port, ram_rw_1, ram_rw_2;
    logic [AW-1:0] fail_addr, ram_addr_1, ram_addr_2, aq1, aq2;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data, ram_din_1, ram_din_2, ram_dout_1, ram_dout_2;
    logic [DW-1:0] mem [N];

    fault_e fault = F_NONE;
    int     f_addr, f_bit, f_val, f_vict, f_data;
    int     compared = 0;
    int     mismatched = 0;
    res_t   expq [$];

    ram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data), .fail_port(fail_port),
        .ram_rw_1(ram_rw_1), .ram_addr_1(ram_addr_1), .ram_din_1(ram_din_1), .ram_dout_1(ram_dout_1),
        .ram_rw_2(ram_rw_2), .ram_addr_2(ram_addr_2), .ram_din_2(ram_din_2), .ram_dout_2(ram_dout_2)
    );

    always #5 clk = ~clk;

    // RAM: registered addresses, combinational read data, with the selected fault injected
    always @(posedge clk) begin
        aq1 <= ram_addr_1;
        aq2 <= ram_addr_2;
        if (ram_rw_1) begin
            mem[ram_addr_1] <= ram_din_1;
            if (fault == F_COUPLE && int'(ram_addr_1) == f_addr)
                mem[f_vict] <= ram_din_1;
        end
    end

    always_comb begin
        ram_dout_1 = mem[aq1];
        if (fault == F_STUCK && int'(aq1) == f_addr)
            ram_dout_1[f_bit] = f_val[0];
        ram_dout_2 = (fault == F_P2 && int'(aq2) == f_addr) ? f_data[DW-1:0] : mem[aq2];
    end

    // Reference: walk March C- over an array and report the first fault plus busy length
    function automatic res_t model();
        logic [DW-1:0] m [N];
        logic [DW-1:0] want, got1, got2;
        int rdv [6] = '{-1, 0, 1, 0, 1, 0};
        int wrv [6] = '{0, 1, 0, 1, 0, -1};
        bit dn  [6] = '{0, 0, 0, 1, 1, 0};
        int ops, a, b;
        res_t r;
        ops = 0;
        r = '{1'b1, 0, 0, 0, 0, 0};
        for (int i = 0; i < N; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = dn[e] ? N - 1 - k : k;
                b = N - 1 - a;
                if (rdv[e] >= 0) begin
                    ops++;
                    want = rdv[e] == 1 ? '1 : '0;
                    got1 = m[a];
                    if (fault == F_STUCK && a == f_addr) got1[f_bit] = f_val[0];
                    got2 = (fault == F_P2 && b == f_addr) ? f_data[DW-1:0] : m[b];
                    if (got1 != want) begin
                        r = '{1'b0, a, e, int'(got1), 0, ops + 1};
                        return r;
                    end
`ifdef RAM_BIST_PORT2_CHECK_EN
                    if (e == 5 && got2 != want) begin
                        r = '{1'b0, b, e, int'(got2), 1, ops + 1};
                        return r;
                    end
`endif
                end
                if (wrv[e] >= 0) begin
                    ops++;
                    m[a] = wrv[e] == 1 ? '1 : '0;
                    if (fault == F_COUPLE && a == f_addr) m[f_vict] = m[a];
                end
            end
        end
        r.cycles = ops + 1;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: static port-2 rules every cycle, scoreboard pop on each done rising edge
    initial begin
        int bcnt;
        logic done_q;
        logic [AW-1:0] inv;
        res_t e;
        bcnt = 0;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
                done_q = 1'b0;
            end else begin
                inv = ~ram_addr_1;
                check("ram_addr_2", int'(ram_addr_2), int'(inv));
                check("ram_rw_2", int'(ram_rw_2), 0);
                check("ram_din_2", int'(ram_din_2), 0);
                if (busy) bcnt++;
                if (done && !done_q) begin
                    if (expq.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_done: done=1 with no run outstanding");
                    end else begin
                        e = expq.pop_front();
                        check("pass", int'(pass), int'(e.pass));
                        check("fail_addr", int'(fail_addr), e.addr);
                        check("fail_elem", int'(fail_elem), e.elem);
                        check("fail_data", int'(fail_data), e.data);
                        check("fail_port", int'(fail_port), e.port);
                        check("busy_cycles", bcnt, e.cycles);
                    end
                    bcnt = 0;
                end
                done_q = done;
            end
        end
    end

    task automatic issue(input int hold);
        expq.push_back(model());
        start = 1'b1;
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_fail_addr", int'(fail_addr), 0);
        check("rst_fail_elem", int'(fail_elem), 0);
        check("rst_fail_data", int'(fail_data), 0);
        check("rst_fail_port", int'(fail_port), 0);
        check("rst_rw_1", int'(ram_rw_1), 0);
        check("rst_addr_1", int'(ram_addr_1), 0);
        check("rst_din_1", int'(ram_din_1), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        fault = F_NONE;
        issue(1);
        wait_done();

        fault = F_STUCK; f_addr = 5; f_bit = 0; f_val = 1;
        issue(1);
        wait_done();

        fault = F_COUPLE; f_addr = 3; f_vict = 4;
        issue(1);
        wait_done();

        fault = F_NONE;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_rw_1", int'(ram_rw_1), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_addr_1", int'(ram_addr_1), 0);
        issue(1);
        wait_done();

        fault = F_STUCK; f_addr = 9; f_bit = 2; f_val = 0;
        issue(1);
        wait_done();
        fault = F_NONE;
        expq.push_back(model());
        start = 1'b1;
        @(posedge clk);
        #1;
        check("restart_busy", int'(busy), 1);
        check("restart_pass", int'(pass), 0);
        check("restart_fail_addr", int'(fail_addr), 0);
        check("restart_fail_elem", int'(fail_elem), 0);
        check("restart_fail_data", int'(fail_data), 0);
        repeat (99) @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        check("done_held", int'(done), 1);
        check("pass_held", int'(pass), 1);
        issue(1);
        wait_done();

        fault = F_P2; f_addr = 10; f_data = 4;
        issue(1);
        wait_done();

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(3))
                0: fault = F_NONE;
                1: begin
                    fault = F_STUCK;
                    f_addr = $urandom_range(N - 1);
                    f_bit = $urandom_range(DW - 1);
                    f_val = $urandom_range(1);
                end
                2: begin
                    fault = F_COUPLE;
                    f_addr = $urandom_range(N - 1);
                    f_vict = (f_addr + $urandom_range(N - 1, 1)) % N;
                end
                default: begin
                    fault = F_P2;
                    f_addr = $urandom_range(N - 1);
                    f_data = $urandom_range(15, 1);
                end
            endcase
            repeat ($urandom_range(4)) @(posedge clk);
            #1;
            issue($urandom_range(8, 1));
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
